// File: rtl/riscv_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_mem_pkg
//  Purpose  : Shared definitions for the data-memory responder: RV32I funct3
//             access-size codes, load/store opcodes and the access FSM states.
//  Revision : 1.0 - initial release
// ============================================================================
package riscv_mem_pkg;

  // funct3 (instr[14:12]) access-size / sign codes
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Major opcodes that raise a memory access in the main decoder
  localparam logic [6:0] LOAD  = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mem_state_t;

endpackage : riscv_mem_pkg
`default_nettype wire

// File: rtl/mem_lane_format.sv
`default_nettype none
// ============================================================================
//  Module   : mem_lane_format
//  Purpose  : Combinational RV32I lane formatter. Produces store byte enables
//             and replicated store data, extracts/extends load data from the
//             addressed word, and flags illegal funct3 or misaligned accesses.
//  Ports    : funct3   in  access size/sign
//             addr_lo  in  byte offset within the word
//             is_store in  1 = store, 0 = load
//             wr_data  in  raw store data (rs2)
//             rd_word  in  full word read from the array
//             byte_en  out per-lane write enables (0 on error)
//             wr_word  out store data replicated onto the lanes
//             rd_data  out formatted load data
//             err      out illegal funct3 or misaligned
//  Revision : 1.0 - initial release
// ============================================================================
module mem_lane_format
  import riscv_mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic        is_store,
  input  logic [31:0] wr_data,
  input  logic [31:0] rd_word,
  output logic [3:0]  byte_en,
  output logic [31:0] wr_word,
  output logic [31:0] rd_data,
  output logic        err
);

  logic       w_illegal;
  logic       w_misalign;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    // Stores only know B/H/W; loads add the unsigned B/H variants.
    w_illegal = 1'b1;
    case (funct3)
      F3_B, F3_H, F3_W: w_illegal = 1'b0;
      F3_BU, F3_HU:     w_illegal = is_store;
      default:          w_illegal = 1'b1;
    endcase

    // funct3[1:0] encodes the size for every legal code
    w_misalign = ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
                 ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));
    err = w_illegal | w_misalign;

    case (addr_lo)
      2'd0:    w_byte = rd_word[7:0];
      2'd1:    w_byte = rd_word[15:8];
      2'd2:    w_byte = rd_word[23:16];
      default: w_byte = rd_word[31:24];
    endcase
    w_half = addr_lo[1] ? rd_word[31:16] : rd_word[15:0];

    byte_en = 4'b0000;
    wr_word = wr_data;
    rd_data = 32'd0;
    if (!err) begin
      case (funct3[1:0])
        2'b00: begin
          byte_en = 4'b0001 << addr_lo;
          wr_word = {4{wr_data[7:0]}};
          rd_data = funct3[2] ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
        end
        2'b01: begin
          byte_en = addr_lo[1] ? 4'b1100 : 4'b0011;
          wr_word = {2{wr_data[15:0]}};
          rd_data = funct3[2] ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
        end
        default: begin
          byte_en = 4'b1111;
          wr_word = wr_data;
          rd_data = rd_word;
        end
      endcase
    end
  end

endmodule : mem_lane_format
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem_responder
//  Purpose  : Data-memory responder for the core. Accepts a load/store when
//             Mem & (MemRead|MemWrite), waits WAIT_CYCLES cycles, then commits
//             and pulses Ready for one cycle. Stall freezes the core until the
//             access reaches DONE.
//  Ports    : clk, reset           clock / async active-high reset
//             Mem, MemRead,
//             MemWrite              request qualifier and direction
//             Funct3, Addr, WrData  access size, byte address, store data
//             RdData                formatted load data (valid with Ready)
//             Ready, Err            completion pulse and reject flag
//             Stall                 core hold request
//  Revision : 1.0 - initial release
// ============================================================================
module data_mem_responder
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_W      = 9,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Mem,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [2:0]        Funct3,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [31:0]       WrData,
  output logic [31:0]       RdData,
  output logic              Ready,
  output logic              Err,
  output logic              Stall
);

  localparam int         c_WORDS = 2 ** (ADDR_W - 2);
  localparam logic [3:0] c_WAIT  = 4'(WAIT_CYCLES);

  mem_state_t r_state, w_state_next;
  logic [3:0]        r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [2:0]        r_funct3;
  logic [31:0]       r_wr_data;
  logic              r_rd, r_wr;

  logic [31:0] r_mem [c_WORDS];

  logic              w_req;
  logic              w_commit;
  logic [ADDR_W-1:0] w_addr;
  logic [2:0]        w_funct3;
  logic [31:0]       w_wr_data;
  logic              w_rd, w_wr;
  logic [31:0]       w_rd_word;
  logic [3:0]        w_byte_en;
  logic [31:0]       w_wr_word;
  logic [31:0]       w_rd_data;
  logic              w_fmt_err;
  logic              w_err;

  assign w_req = Mem & (MemRead | MemWrite);

  // With zero wait states the commit edge is the request cycle itself, so
  // the live inputs feed the formatter in IDLE and the latched copy after.
  assign w_addr    = (r_state == IDLE) ? Addr     : r_addr;
  assign w_funct3  = (r_state == IDLE) ? Funct3   : r_funct3;
  assign w_wr_data = (r_state == IDLE) ? WrData   : r_wr_data;
  assign w_rd      = (r_state == IDLE) ? MemRead  : r_rd;
  assign w_wr      = (r_state == IDLE) ? MemWrite : r_wr;

  assign w_rd_word = r_mem[w_addr[ADDR_W-1:2]];

  mem_lane_format u_fmt (
    .funct3   (w_funct3),
    .addr_lo  (w_addr[1:0]),
    .is_store (w_wr),
    .wr_data  (w_wr_data),
    .rd_word  (w_rd_word),
    .byte_en  (w_byte_en),
    .wr_word  (w_wr_word),
    .rd_data  (w_rd_data),
    .err      (w_fmt_err)
  );

  assign w_err = w_fmt_err | (w_rd & w_wr);

  always_comb begin
    w_state_next = r_state;
    w_commit     = 1'b0;
    Stall        = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          Stall = 1'b1;
          if (c_WAIT == 4'd0) begin
            w_state_next = DONE;
            w_commit     = 1'b1;
          end else begin
            w_state_next = WAIT;
          end
        end
      end
      WAIT: begin
        Stall = 1'b1;
        if (r_cnt <= 4'd1) begin
          w_state_next = DONE;
          w_commit     = 1'b1;
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
    // Reset drops Stall in the same cycle it is raised
    if (reset) begin
      Stall    = 1'b0;
      w_commit = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= 4'd0;
      r_addr    <= '0;
      r_funct3  <= 3'd0;
      r_wr_data <= 32'd0;
      r_rd      <= 1'b0;
      r_wr      <= 1'b0;
      RdData    <= 32'd0;
      Err       <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (r_state == IDLE && w_req) begin
        r_addr    <= Addr;
        r_funct3  <= Funct3;
        r_wr_data <= WrData;
        r_rd      <= MemRead;
        r_wr      <= MemWrite;
        r_cnt     <= c_WAIT;
      end else if (r_state == WAIT && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      Err <= w_commit & w_err;
      if (w_commit) begin
        if (w_err)     RdData <= 32'd0;
        else if (w_rd) RdData <= w_rd_data;
      end
    end
  end

  assign Ready = (r_state == DONE);

  // Array is not reset; the write is gated by the commit strobe only.
  always_ff @(posedge clk) begin
    if (w_commit && w_wr && !w_err) begin
      for (int i = 0; i < 4; i++) begin
        if (w_byte_en[i]) r_mem[w_addr[ADDR_W-1:2]][8*i +: 8] <= w_wr_word[8*i +: 8];
      end
    end
  end

endmodule : data_mem_responder
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_data_mem_responder
//  Purpose  : Self-checking bench for data_mem_responder. Expected responses
//             are queued when a request is driven and compared when Ready
//             pulses. A second instance is built with zero wait states.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

  typedef struct {
    string       tag;
    bit          chk_rd;
    logic [31:0] exp_rd;
    logic        exp_err;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_s = 1'b0, rd_s = 1'b0, wr_s = 1'b0;
  logic [2:0]  f3_s = 3'd0;
  logic [8:0]  addr_s = 9'd0;
  logic [31:0] wd_s = 32'd0;
  logic [31:0] rdata_s, rdata_f;
  logic        ready_s, err_s, stall_s;
  logic        ready_f, err_f, stall_f;
  logic        mem_f = 1'b0, rd_f = 1'b0, wr_f = 1'b0;
  logic [2:0]  f3_f = 3'd0;
  logic [8:0]  addr_f = 9'd0;
  logic [31:0] wd_f = 32'd0;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.ADDR_W(9), .WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .Mem(mem_s), .MemRead(rd_s), .MemWrite(wr_s),
    .Funct3(f3_s), .Addr(addr_s), .WrData(wd_s), .RdData(rdata_s),
    .Ready(ready_s), .Err(err_s), .Stall(stall_s)
  );

  data_mem_responder #(.ADDR_W(9), .WAIT_CYCLES(0)) dut_fast (
    .clk(clk), .reset(reset), .Mem(mem_f), .MemRead(rd_f), .MemWrite(wr_f),
    .Funct3(f3_f), .Addr(addr_f), .WrData(wd_f), .RdData(rdata_f),
    .Ready(ready_f), .Err(err_f), .Stall(stall_f)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Drive one access, hold it until Ready, and score the response.
  task automatic access(input bit fast, input bit m, input bit r, input bit w,
                        input logic [2:0] f3, input logic [8:0] a, input logic [31:0] wd,
                        input bit chk_rd, input logic [31:0] exp_rd, input bit exp_err,
                        input string tag);
    exp_t e;
    int   stalls = 0;
    bit   got = 0;
    e.tag = tag; e.chk_rd = chk_rd; e.exp_rd = exp_rd; e.exp_err = exp_err;
    sb_q.push_back(e);
    if (fast) begin
      mem_f = m; rd_f = r; wr_f = w; f3_f = f3; addr_f = a; wd_f = wd;
    end else begin
      mem_s = m; rd_s = r; wr_s = w; f3_s = f3; addr_s = a; wd_s = wd;
    end
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (fast ? stall_f : stall_s) stalls++;
      if (fast ? ready_f : ready_s) begin
        got = 1;
        if (sb_q.size() == 0) begin
          check_eq({tag, "_unexpected_ready"}, 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check_eq({e.tag, "_err"}, {31'd0, fast ? err_f : err_s}, {31'd0, e.exp_err});
          if (e.chk_rd) check_eq({e.tag, "_rdata"}, fast ? rdata_f : rdata_s, e.exp_rd);
        end
      end
    end
    if (!got) begin
      check_eq({tag, "_ready_timeout"}, 32'd0, 32'd1);
      void'(sb_q.pop_front());
    end
    check_eq({tag, "_stall_cycles"}, stalls, fast ? 32'd1 : 32'd3);
    @(posedge clk); #1;
    if (fast) begin
      mem_f = 0; rd_f = 0; wr_f = 0;
    end else begin
      mem_s = 0; rd_s = 0; wr_s = 0;
    end
  endtask

  initial begin
    bit bad;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_rdata", rdata_s, 32'd0);
    check_eq("rst_ready", {31'd0, ready_s}, 32'd0);
    check_eq("rst_err",   {31'd0, err_s},   32'd0);
    check_eq("rst_stall", {31'd0, stall_s}, 32'd0);
    reset = 0;
    @(posedge clk); #1;

    // Word store / load
    access(0, 1, 0, 1, 3'b010, 9'h010, 32'hDEADBEEF, 0, 0, 0, "sw_10");
    access(0, 1, 1, 0, 3'b010, 9'h010, 0, 1, 32'hDEADBEEF, 0, "lw_10");
    // Byte store into lane 3, then sub-word loads
    access(0, 1, 0, 1, 3'b000, 9'h013, 32'h000000A5, 0, 0, 0, "sb_13");
    access(0, 1, 1, 0, 3'b000, 9'h013, 0, 1, 32'hFFFFFFA5, 0, "lb_13");
    access(0, 1, 1, 0, 3'b100, 9'h013, 0, 1, 32'h000000A5, 0, "lbu_13");
    access(0, 1, 1, 0, 3'b010, 9'h010, 0, 1, 32'hA5ADBEEF, 0, "lw_10b");
    access(0, 1, 1, 0, 3'b001, 9'h012, 0, 1, 32'hFFFFA5AD, 0, "lh_12");
    access(0, 1, 1, 0, 3'b001, 9'h010, 0, 1, 32'hFFFFBEEF, 0, "lh_10");
    access(0, 1, 1, 0, 3'b101, 9'h010, 0, 1, 32'h0000BEEF, 0, "lhu_10");
    // Misaligned and illegal accesses
    access(0, 1, 0, 1, 3'b001, 9'h011, 32'h1234, 0, 0, 1, "sh_mis");
    access(0, 1, 1, 0, 3'b010, 9'h012, 0, 1, 32'd0, 1, "lw_mis");
    access(0, 1, 0, 1, 3'b100, 9'h010, 32'h0, 1, 32'd0, 1, "st_f3_100");
    access(0, 1, 1, 1, 3'b010, 9'h010, 32'h0, 1, 32'd0, 1, "rd_and_wr");
    access(0, 1, 1, 0, 3'b011, 9'h010, 0, 1, 32'd0, 1, "ld_f3_011");
    access(0, 1, 1, 0, 3'b010, 9'h010, 0, 1, 32'hA5ADBEEF, 0, "lw_after_err");

    // JALR: MemWrite without Mem must be ignored
    mem_s = 0; wr_s = 1; f3_s = 3'b010; addr_s = 9'h010; wd_s = 32'd0;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (stall_s || ready_s) bad = 1;
    end
    check_eq("jalr_ignored", {31'd0, bad}, 32'd0);
    @(posedge clk); #1;
    wr_s = 0;
    access(0, 1, 1, 0, 3'b010, 9'h010, 0, 1, 32'hA5ADBEEF, 0, "lw_after_jalr");

    // Reset during WAIT discards the pending store
    access(0, 1, 0, 1, 3'b010, 9'h020, 32'h11223344, 0, 0, 0, "sw_20");
    mem_s = 1; wr_s = 1; f3_s = 3'b010; addr_s = 9'h020; wd_s = 32'h55;
    @(posedge clk); #1;
    check_eq("wait_stall", {31'd0, stall_s}, 32'd1);
    #2 reset = 1;
    #1;
    check_eq("rst_mid_stall", {31'd0, stall_s}, 32'd0);
    check_eq("rst_mid_ready", {31'd0, ready_s}, 32'd0);
    @(posedge clk); #1;
    mem_s = 0; wr_s = 0;
    reset = 0;
    @(posedge clk); #1;
    access(0, 1, 1, 0, 3'b010, 9'h020, 0, 1, 32'h11223344, 0, "lw_20");

    // Zero-wait-state instance
    access(1, 1, 0, 1, 3'b010, 9'h040, 32'hCAFEF00D, 0, 0, 0, "fast_sw");
    access(1, 1, 1, 0, 3'b010, 9'h040, 0, 1, 32'hCAFEF00D, 0, "fast_lw");
    access(1, 1, 1, 0, 3'b000, 9'h041, 0, 1, 32'hFFFFFFF0, 0, "fast_lb");

    check_eq("sb_empty", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_data_mem_responder
`default_nettype wire
